wb_stage: RTL

Writeback stage of the rv32 pipeline and the consumer of the 2-bit wb_sel code produced by the control decode. It accepts one retiring instruction per handshake from the MEM stage and selects the writeback source by wb_sel. For loads it waits for the data-memory response and byte/half-formats it. It then drives a single registered register-file write port plus a forwarding copy for the hazard unit.

---
 rtl/wb_stage_if.sv | 45 ++++
 rtl/wb_stage.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/wb_stage_if.sv
// Bundle for wb_stage: MEM-stage handshake, data-memory load response,
// register-file write / forwarding port, status pulses and FSM debug state.
//
// Handshake: an instruction moves from MEM into wb_stage on a clock edge
// where in_valid && in_ready are both 1. The payload (in_wb_sel, in_rd,
// in_rd_we, in_funct3, in_alu_res, in_pc_plus4) must be stable while
// in_valid is 1. in_ready depends only on wb_stage state, never on in_valid.
// ld_rsp_valid is a single-cycle pulse with no back-pressure.
interface wb_stage_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [1:0]      in_wb_sel;
  logic [4:0]      in_rd;
  logic            in_rd_we;
  logic [2:0]      in_funct3;
  logic [XLEN-1:0] in_alu_res;
  logic [XLEN-1:0] in_pc_plus4;
  logic            ld_rsp_valid;
  logic [XLEN-1:0] ld_rsp_data;
  logic            rf_we;
  logic [4:0]      rf_waddr;
  logic [XLEN-1:0] rf_wdata;
  logic            fwd_valid;
  logic            ld_err;
  logic            spurious_rsp;
  logic            dbg_state;

  // Upstream side: MEM stage plus data-memory response source
  modport master (
    output in_valid, in_wb_sel, in_rd, in_rd_we, in_funct3,
           in_alu_res, in_pc_plus4, ld_rsp_valid, ld_rsp_data,
    input  in_ready, rf_we, rf_waddr, rf_wdata, fwd_valid,
           ld_err, spurious_rsp, dbg_state
  );

  // wb_stage side
  modport slave (
    input  in_valid, in_wb_sel, in_rd, in_rd_we, in_funct3,
           in_alu_res, in_pc_plus4, ld_rsp_valid, ld_rsp_data,
    output in_ready, rf_we, rf_waddr, rf_wdata, fwd_valid,
           ld_err, spurious_rsp, dbg_state
  );
endinterface

// File: rtl/wb_stage.sv
// rv32 writeback stage. Selects the writeback source from wb_sel, waits for
// and formats load responses, and drives one registered register-file write
// port that also serves as the forwarding bus for the hazard unit.
module wb_stage #(
  parameter int XLEN       = 32,
  parameter int LD_TIMEOUT = 15
) (
  input logic        clk,
  input logic        rst,
  wb_stage_if.slave  bus
);

  localparam int CW = $clog2(LD_TIMEOUT + 1);

  localparam logic [1:0] SEL_MEM  = 2'b00;
  localparam logic [1:0] SEL_ALU  = 2'b01;
  localparam logic [1:0] SEL_PC4  = 2'b10;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    WAIT_LD = 1'b1
  } state_t;

  // State and latched load context
  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic [4:0]      r_rd;
  logic [2:0]      r_funct3;
  logic [1:0]      r_off;

  // Registered outputs
  logic            r_rf_we;
  logic [4:0]      r_rf_waddr;
  logic [XLEN-1:0] r_rf_wdata;
  logic            r_ld_err;
  logic            r_spurious;

  // Next-state values
  state_t          w_state_nxt;
  logic [CW-1:0]   w_cnt_nxt;
  logic [4:0]      w_rd_nxt;
  logic [2:0]      w_funct3_nxt;
  logic [1:0]      w_off_nxt;
  logic            w_we_nxt;
  logic [4:0]      w_waddr_nxt;
  logic [XLEN-1:0] w_wdata_nxt;
  logic            w_err_nxt;
  logic            w_spur_nxt;

  // Load formatting
  logic [7:0]      w_ld_byte;
  logic [15:0]     w_ld_half;
  logic [XLEN-1:0] w_ld_fmt;
  logic            w_ld_bad;
  logic            w_in_wr_ok;
  logic            w_timeout;

  // A write only happens for a real destination register
  assign w_in_wr_ok = bus.in_rd_we && (bus.in_rd != 5'd0);

  // Last WAIT_LD cycle before the load is abandoned
  assign w_timeout = (r_cnt == CW'(LD_TIMEOUT - 1));

  // Pick the addressed byte and half out of the aligned response word
  always_comb begin
    w_ld_byte = bus.ld_rsp_data[7:0];
    case (r_off)
      2'd0:    w_ld_byte = bus.ld_rsp_data[7:0];
      2'd1:    w_ld_byte = bus.ld_rsp_data[15:8];
      2'd2:    w_ld_byte = bus.ld_rsp_data[23:16];
      default: w_ld_byte = bus.ld_rsp_data[31:24];
    endcase
    w_ld_half = r_off[1] ? bus.ld_rsp_data[31:16] : bus.ld_rsp_data[15:0];
  end

  // Sign/zero extend by load size and flag misaligned or unknown sizes
  always_comb begin
    w_ld_fmt = bus.ld_rsp_data;
    w_ld_bad = 1'b0;
    case (r_funct3)
      F3_LB:  w_ld_fmt = {{(XLEN-8){w_ld_byte[7]}}, w_ld_byte};
      F3_LBU: w_ld_fmt = {{(XLEN-8){1'b0}}, w_ld_byte};
      F3_LH: begin
        w_ld_fmt = {{(XLEN-16){w_ld_half[15]}}, w_ld_half};
        w_ld_bad = r_off[0];
      end
      F3_LHU: begin
        w_ld_fmt = {{(XLEN-16){1'b0}}, w_ld_half};
        w_ld_bad = r_off[0];
      end
      F3_LW: begin
        w_ld_fmt = bus.ld_rsp_data;
        w_ld_bad = (r_off != 2'd0);
      end
      default: begin
        w_ld_fmt = bus.ld_rsp_data;
        w_ld_bad = 1'b1;
      end
    endcase
  end

  // FSM next state plus next values of every registered output
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_rd_nxt     = r_rd;
    w_funct3_nxt = r_funct3;
    w_off_nxt    = r_off;
    w_we_nxt     = 1'b0;
    w_waddr_nxt  = r_rf_waddr;
    w_wdata_nxt  = r_rf_wdata;
    w_err_nxt    = 1'b0;
    w_spur_nxt   = 1'b0;

    case (r_state)
      IDLE: begin
        // A response with no load outstanding is reported, never written
        w_spur_nxt = bus.ld_rsp_valid;
        w_cnt_nxt  = '0;
        if (bus.in_valid) begin
          case (bus.in_wb_sel)
            SEL_ALU: begin
              if (w_in_wr_ok) begin
                w_we_nxt    = 1'b1;
                w_waddr_nxt = bus.in_rd;
                w_wdata_nxt = bus.in_alu_res;
              end
            end
            SEL_PC4: begin
              if (w_in_wr_ok) begin
                w_we_nxt    = 1'b1;
                w_waddr_nxt = bus.in_rd;
                w_wdata_nxt = bus.in_pc_plus4;
              end
            end
            SEL_MEM: begin
              // Stores/fence/system carry rd_we=0 and retire here.
              // Loads to x0 still wait so their response is consumed.
              if (bus.in_rd_we) begin
                w_rd_nxt     = bus.in_rd;
                w_funct3_nxt = bus.in_funct3;
                w_off_nxt    = bus.in_alu_res[1:0];
                w_state_nxt  = WAIT_LD;
              end
            end
            default: ;
          endcase
        end
      end

      WAIT_LD: begin
        if (bus.ld_rsp_valid) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
          if (w_ld_bad) begin
            w_err_nxt = 1'b1;
          end else if (r_rd != 5'd0) begin
            w_we_nxt    = 1'b1;
            w_waddr_nxt = r_rd;
            w_wdata_nxt = w_ld_fmt;
          end
        end else if (w_timeout) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
          w_err_nxt   = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end

      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // FSM state register; reset abandons any outstanding load
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Latched load context, only meaningful while in WAIT_LD
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rd     <= 5'd0;
      r_funct3 <= 3'd0;
      r_off    <= 2'd0;
    end else begin
      r_rd     <= w_rd_nxt;
      r_funct3 <= w_funct3_nxt;
      r_off    <= w_off_nxt;
    end
  end

  // Registered write port and status pulses
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rf_we    <= 1'b0;
      r_rf_waddr <= 5'd0;
      r_rf_wdata <= '0;
      r_ld_err   <= 1'b0;
      r_spurious <= 1'b0;
    end else begin
      r_rf_we    <= w_we_nxt;
      r_rf_waddr <= w_waddr_nxt;
      r_rf_wdata <= w_wdata_nxt;
      r_ld_err   <= w_err_nxt;
      r_spurious <= w_spur_nxt;
    end
  end

  assign bus.in_ready     = (r_state == IDLE);
  assign bus.rf_we        = r_rf_we;
  assign bus.rf_waddr     = r_rf_waddr;
  assign bus.rf_wdata     = r_rf_wdata;
  assign bus.fwd_valid    = r_rf_we;
  assign bus.ld_err       = r_ld_err;
  assign bus.spurious_rsp = r_spurious;
  assign bus.dbg_state    = r_state;

endmodule
